// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
package div_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned CntWidth = $clog2(DefWidth + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o,
  output logic             non_neg_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, quo_msb_i};
  // The extra bit keeps the borrow visible even when divisor_i uses the full width.
  assign diff      = shifted - {1'b0, divisor_i};
  assign non_neg_o = ~diff[WIDTH];
  assign q_bit_o   = non_neg_o;
  assign rem_o     = non_neg_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned modes and
// divide-by-zero / overflow reporting.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             is_signed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             neg_quo_q, neg_rem_q, dz_q, ovf_q;
  logic             busy_q, done_q, div_by_zero_q, overflow_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             dvd_neg, dvs_neg, dz_start, ovf_start;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit, step_non_neg;

  // Negating MIN yields MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign dvd_neg   = is_signed_i & dividend_i[WIDTH-1];
  assign dvs_neg   = is_signed_i & divisor_i[WIDTH-1];
  assign dvd_abs   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign dvs_abs   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign dz_start  = (divisor_i == '0);
  assign ovf_start = is_signed_i & (dividend_i == MinVal) & (divisor_i == '1);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_msb_i(quo_q[WIDTH-1]),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_qbit),
    .non_neg_o(step_non_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            rem_q     <= '0;
            cnt_q     <= '0;
            dvsr_q    <= dvs_abs;
            // On divide-by-zero the raw dividend rides in quo_q to become the remainder.
            quo_q     <= dz_start ? dividend_i : dvd_abs;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            dz_q      <= dz_start;
            ovf_q     <= ovf_start;
            state_q   <= dz_start ? StFix : StCalc;
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_qbit & step_non_neg};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          if (dz_q) begin
            quotient_q  <= '1;
            remainder_q <= quo_q;
          end else begin
            quotient_q  <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            remainder_q <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          end
          div_by_zero_q <= dz_q;
          overflow_q    <= ovf_q;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with hand-computed expectations.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .is_signed_i  (is_signed),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero),
    .overflow_o   (overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts one operation and returns at #1 after the edge where done rises.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int poke, output int lat);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy after start", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == poke) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd5;
      end else if (lat == poke + 1) begin
        start = 1'b0;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done timeout: got no done, expected done within 100 cycles");
    end
  endtask

  vec_t vecs[7];
  int   lat;
  int   cnt;
  logic saw_done;

  initial begin
    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
    vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33};
    vecs[3] = '{32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33};
    vecs[5] = '{32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, -1, lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d div_by_zero", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
      chk($sformatf("v%0d overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ov});
      chk($sformatf("v%0d busy in done cycle", i), {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done width", i), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d quotient held", i), quotient, vecs[i].q);
    end

    // Start re-pulsed mid-operation must be ignored.
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 10, lat);
    chk("ignored-start latency", lat, 33);
    chk("ignored-start quotient", quotient, 32'hFFFF_FFFF);
    chk("ignored-start remainder", remainder, 32'd0);
    @(posedge clk);
    #1;
    chk("ignored-start idle after", {31'b0, busy}, 32'd0);

    // Reset mid-CALC aborts with no done.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    is_signed = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", {31'b0, saw_done}, 32'd0);
    run_op(32'd50, 32'd5, 1'b0, -1, lat);
    chk("post-reset quotient", quotient, 32'd10);
    chk("post-reset remainder", remainder, 32'd0);

    // Back-to-back: next start sampled in the done cycle.
    @(posedge clk);
    #1;
    run_op(32'd9, 32'd3, 1'b0, -1, lat);
    chk("b2b first quotient", quotient, 32'd3);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd4;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt++;
    end while (!done && cnt < 100);
    chk("b2b gap", cnt, 34);
    chk("b2b second quotient", quotient, 32'd2);
    chk("b2b second remainder", remainder, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring integer divider: the inverse of the adder/multiplier datapaths in this chip. It accepts a dividend/divisor pair on a single-cycle start strobe and runs one trial subtraction per clock. It returns quotient, remainder and status flags with a one-cycle done pulse. It sits beside the adder and multiplier blocks as the chip's division unit and reuses subtract-based arithmetic.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  two's-complement or unsigned per is_signed
- divisor  in  WIDTH  two's-complement or unsigned per is_signed
- is_signed  in  1  1 = signed division, 0 = unsigned; sampled with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when results are valid
- quotient  out  WIDTH  result, held until next accepted start
- remainder  out  WIDTH  result, held until next accepted start
- div_by_zero  out  1  divisor was 0; held with results
- overflow  out  1  signed MIN / -1; held with results

## Operation
- States are IDLE, CALC, FIX.
- **IDLE:**
  - start=1 latches the operands, is_signed and the flags.
  - In signed mode it takes absolute values (|MIN| = 2^(WIDTH-1) as unsigned).
  - It clears the partial remainder, sets count = 0, and moves to CALC.
  - divisor = 0 goes to FIX directly.
  - Flags clear on every accepted start.
- **CALC:** once per cycle:
  - Shift {rem, quo} left 1.
  - Trial-subtract |divisor| from rem using a WIDTH+1-bit difference.
  - If the difference is non-negative: commit it and set the quotient LSB to 1. Otherwise restore and set it to 0.
  - After WIDTH iterations, go to FIX.
- **FIX:**
  - Apply sign: the quotient is negated if the operand signs differ (signed mode only). The remainder takes the sign of the dividend (truncating division).
  - Register quotient/remainder, pulse done, return to IDLE.
- **Divide by zero:** quotient = all ones, remainder = dividend unmodified, div_by_zero = 1.
- **Signed MIN / -1:** quotient = MIN, remainder = 0, overflow = 1. This falls out of the algorithm; the flag is decoded at start.
- start while busy is ignored (not queued).
- is_signed = 0 never raises overflow.

## Timing
- **Reset values:** busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state IDLE.
- Let E0 be the edge that samples start.
  - busy=1 from E0 until the edge that enters IDLE.
  - Normal path: CALC iterations on E1..E_WIDTH. FIX writes results at E_(WIDTH+1).
  - done is high for exactly one cycle after E_(WIDTH+1): 33 cycles after E0 for WIDTH = 32.
- **Divide-by-zero path:** FIX at E1; done is high in the cycle after E1.
- **Back-to-back:** busy drops in the same cycle done rises. A start sampled during that cycle is accepted, giving a 1-cycle gap between operations.
- Results and flags change only at the FIX edge and at reset.
- **Reset asserted mid-operation:** immediate return to reset values. The aborted operation produces no done.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the default WIDTH;
  - a localparam for the counter width, $clog2(WIDTH+1).
- One sub-module, div_step: combinational single iteration. It takes rem, quo MSB and |divisor| and returns the next rem, the quotient bit, and a non-negative flag. It is instantiated once in CALC.
- Sign handling and the FSM stay in seq_divider.

## Test plan
- **Unsigned basic:** 100 / 7, is_signed=0 → quotient=14, remainder=2, flags 0, done 33 cycles after start.
- **Signed truncation:** -7 (0xFFFFFFF9) / 2, is_signed=1 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- **MIN / -1:**
  - 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0, overflow=1.
  - Same operands unsigned → quotient=0, remainder=0x80000000, overflow=0.
- **Divide by zero:** 0x12345678 / 0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, done the cycle after E1.
- **Ignored start and mid-operation reset:**
  - Start is re-pulsed at cycle 10 of 0xFFFFFFFF / 1 unsigned and is ignored. That operation completes with quotient=0xFFFFFFFF, remainder=0.
  - A second operation is then started and rst_n is pulsed low mid-CALC → all outputs 0, no done. A following 50 / 5 start → quotient=10, remainder=0.
- **Back-to-back:** start is asserted in the done cycle of 9 / 3 (quotient=3) with new operands 9 / 4 → second done 34 cycles after the first, quotient=2, remainder=1.
